bsg_gateway_watchdog: RTL and testbench
=======================================

BSG_GATEWAY_WATCHDOG -- requirements
Module: bsg_gateway_watchdog

Interface
REQ-001 The block SHALL have parameter num_channels_p, default 2, number of independently monitored channels; legal range 1..16.
REQ-002 The block SHALL have parameter timeout_cycles_p, default 500000, number of enabled idle cycles before a channel expires; legal minimum 2.
REQ-003 The block SHALL have parameter heartbeat_log_p, default 16, log2 of heartbeat period; used only when the heartbeat is compiled in.
REQ-004 The block SHALL have input blackparrot_clk, 1 bit, the clock.
REQ-005 The block SHALL have input blackparrot_reset, 1 bit, asynchronous, active-low reset.
REQ-006 The block SHALL have input en_i, 1 bit, global count enable.
REQ-007 The block SHALL have input activity_i, num_channels_p bits, per-channel progress strobe.
REQ-008 The block SHALL have input clear_i, num_channels_p bits, per-channel re-arm.
REQ-009 The block SHALL have output timeout_o, num_channels_p bits, sticky per-channel expired flag.
REQ-010 The block SHALL have output any_timeout_o, 1 bit, OR of timeout_o.
REQ-011 The block SHALL have output event_v_o, 1 bit, a timeout event is pending.
REQ-012 The block SHALL have output event_id_o, clog2(num_channels_p) bits (minimum 1), the pending channel index.
REQ-013 The block SHALL have input event_yumi_i, 1 bit, consumer accepts the event.
REQ-014 The block SHALL have output heartbeat_o, 1 bit, periodic pulse; tied 0 when the heartbeat is compiled out.

Function
REQ-015 Each channel SHALL hold a counter of width clog2(timeout_cycles_p+1) and a state in {COUNTING, EXPIRED}.
REQ-016 In COUNTING, activity_i[c]=1 SHALL load the counter with 0, regardless of en_i.
REQ-017 In COUNTING, with activity_i[c]=0 and en_i=1, the counter SHALL increment by 1.
REQ-018 With en_i=0 and no activity, the counter SHALL hold.
REQ-019 In COUNTING, with counter==timeout_cycles_p-1, en_i=1 and activity_i[c]=0, the channel SHALL move to EXPIRED at the next edge, setting timeout_o[c] and pending[c]. The timeout therefore follows exactly timeout_cycles_p consecutive enabled idle cycles.
REQ-020 In EXPIRED, activity_i[c] SHALL be ignored and timeout_o[c] SHALL stay 1.
REQ-021 The counter SHALL never exceed timeout_cycles_p-1; there is no wrap-around.
REQ-022 clear_i[c]=1 SHALL, at the next edge, put the channel in COUNTING with counter 0, timeout_o[c]=0 and pending[c]=0, from any state.
REQ-023 clear_i[c] SHALL win over a simultaneous expiry and over a simultaneous activity on the same channel.
REQ-024 event_v_o SHALL equal the OR of the pending bits; event_id_o SHALL be the lowest-indexed pending channel, combinationally derived.
REQ-025 When event_yumi_i=1 and event_v_o=1, the pending bit for event_id_o SHALL clear at the next edge; timeout_o is unaffected.
REQ-026 event_yumi_i=1 while event_v_o=0 SHALL be ignored.
REQ-027 A new expiry on a lower index in the same cycle as a yumi SHALL become visible next cycle; the yumi applies to the index shown when the yumi was asserted.
REQ-028 Simultaneous expiry of several channels SHALL set all of their pending bits; events are reported in ascending index order.
REQ-029 The outputs SHALL be registered state or combinational functions of registered state only; there is no combinational input-to-output path except none.

Reset
REQ-030 While blackparrot_reset=0, all channels SHALL be in COUNTING with counter 0, and pending, timeout_o, any_timeout_o, event_v_o, event_id_o and heartbeat_o SHALL be 0.
REQ-031 Reset asserted mid-count or while an event is pending SHALL discard all state immediately, with no event emitted.

Configuration
REQ-032 With macro BSG_GATEWAY_WATCHDOG_HEARTBEAT_EN defined, a heartbeat_log_p-bit free-running counter SHALL advance every cycle. heartbeat_o SHALL pulse 1 for one cycle when that counter wraps to 0, i.e. every 2^heartbeat_log_p cycles, the first pulse at cycle 2^heartbeat_log_p after reset release.
REQ-033 Without BSG_GATEWAY_WATCHDOG_HEARTBEAT_EN, the heartbeat counter SHALL be absent and heartbeat_o SHALL be constant 0.

Verification
REQ-034 Scenario: timeout_cycles_p=8, en_i=1, no activity on channel 0 -> timeout_o[0] rises exactly 8 cycles after reset release; event_v_o=1, event_id_o=0.
REQ-035 Scenario: activity_i[0] pulsed every 7 cycles for 100 cycles -> timeout_o[0] never asserts; activity stopped -> expires 8 cycles later.
REQ-036 Scenario: channels 1 and 3 expire in the same cycle (num_channels_p=4), yumi held 1 -> event_id_o reads 1 then 3 on consecutive cycles, then event_v_o=0; timeout_o=4'b1010 remains.
REQ-037 Scenario: clear_i[0] asserted in the exact expiry cycle -> timeout_o[0] stays 0, counter=0, no event; en_i=0 for 20 cycles -> counters hold, no expiry.
REQ-038 Scenario: reset asserted while event_v_o=1 -> all outputs 0 during reset; after release, a fresh full 8-cycle timeout is required.
REQ-039 Scenario: macro defined, heartbeat_log_p=4 -> heartbeat_o pulses at cycles 16, 32, 48 after release; macro undefined -> heartbeat_o stays 0.

Source files
------------

// File: rtl/bsg_gateway_watchdog.sv
// Per-channel idle watchdog with sticky timeout flags and a lowest-index event queue.
// Optional heartbeat pulse compiled in with BSG_GATEWAY_WATCHDOG_HEARTBEAT_EN.
module bsg_gateway_watchdog #(
  parameter int num_channels_p   = 2,
  parameter int timeout_cycles_p = 500000,
  parameter int heartbeat_log_p  = 16,
  localparam int id_w_lp = (num_channels_p > 1) ? $clog2(num_channels_p) : 1
) (
  input  logic                      blackparrot_clk,
  input  logic                      blackparrot_reset,
  input  logic                      en_i,
  input  logic [num_channels_p-1:0] activity_i,
  input  logic [num_channels_p-1:0] clear_i,
  output logic [num_channels_p-1:0] timeout_o,
  output logic                      any_timeout_o,
  output logic                      event_v_o,
  output logic [id_w_lp-1:0]        event_id_o,
  input  logic                      event_yumi_i,
  output logic                      heartbeat_o
);

  localparam int cnt_w_lp = $clog2(timeout_cycles_p + 1);
  localparam logic [cnt_w_lp-1:0] last_cnt_lp =
    cnt_w_lp'(timeout_cycles_p - 1);

  localparam logic state_counting = 1'b0;
  localparam logic state_expired  = 1'b1;

  logic [num_channels_p-1:0] state_r;
  logic [num_channels_p-1:0] pending_r;
  logic [cnt_w_lp-1:0]       cnt_r [num_channels_p];

  logic [num_channels_p-1:0] first_pending;
  logic [num_channels_p-1:0] ack;

  // Lowest pending index wins: scan downward so lower bits overwrite.
  always_comb begin
    event_id_o    = '0;
    first_pending = '0;
    for (int i = num_channels_p - 1; i >= 0; i--) begin
      if (pending_r[i]) begin
        event_id_o    = id_w_lp'(i);
        first_pending = '0;
        first_pending[i] = 1'b1;
      end
    end
  end

  assign event_v_o     = |pending_r;
  assign ack           = first_pending & {num_channels_p{event_yumi_i}};
  assign timeout_o     = state_r;
  assign any_timeout_o = |state_r;

  always_ff @(posedge blackparrot_clk or negedge blackparrot_reset) begin
    if (!blackparrot_reset) begin
      state_r   <= {num_channels_p{state_counting}};
      pending_r <= '0;
      for (int c = 0; c < num_channels_p; c++) begin
        cnt_r[c] <= '0;
      end
    end else begin
      for (int c = 0; c < num_channels_p; c++) begin
        if (clear_i[c]) begin
          state_r[c]   <= state_counting;
          pending_r[c] <= 1'b0;
          cnt_r[c]     <= '0;
        end else if (state_r[c] == state_expired) begin
          if (ack[c]) begin
            pending_r[c] <= 1'b0;
          end
        end else if (activity_i[c]) begin
          cnt_r[c] <= '0;
        end else if (en_i) begin
          if (cnt_r[c] == last_cnt_lp) begin
            state_r[c]   <= state_expired;
            pending_r[c] <= 1'b1;
          end else begin
            cnt_r[c] <= cnt_r[c] + cnt_w_lp'(1);
          end
        end
      end
    end
  end

`ifdef BSG_GATEWAY_WATCHDOG_HEARTBEAT_EN
  logic [heartbeat_log_p-1:0] hb_cnt_r;
  logic                       hb_r;

  // Pulse lands on the edge where the counter wraps back to zero.
  always_ff @(posedge blackparrot_clk or negedge blackparrot_reset) begin
    if (!blackparrot_reset) begin
      hb_cnt_r <= '0;
      hb_r     <= 1'b0;
    end else begin
      hb_cnt_r <= hb_cnt_r + heartbeat_log_p'(1);
      hb_r     <= &hb_cnt_r;
    end
  end

  assign heartbeat_o = hb_r;
`else
  assign heartbeat_o = (heartbeat_log_p < 0);
`endif

endmodule

// File: tb/tb_bsg_gateway_watchdog.sv
// Bench for bsg_gateway_watchdog: vector table, directed corner cases,
// and randomized traffic against an idle-run reference model.
module tb_bsg_gateway_watchdog;

  localparam int N  = 4;
  localparam int T  = 8;
  localparam int HB = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         en = 1'b0;
  logic [N-1:0] act = '0;
  logic [N-1:0] clr = '0;
  logic         yumi = 1'b0;
  logic [N-1:0] timeout;
  logic         any_to;
  logic         ev_v;
  logic [1:0]   ev_id;
  logic         hb;

  bsg_gateway_watchdog #(
    .num_channels_p(N),
    .timeout_cycles_p(T),
    .heartbeat_log_p(HB)
  ) dut (
    .blackparrot_clk(clk),
    .blackparrot_reset(rst_n),
    .en_i(en),
    .activity_i(act),
    .clear_i(clr),
    .timeout_o(timeout),
    .any_timeout_o(any_to),
    .event_v_o(ev_v),
    .event_id_o(ev_id),
    .event_yumi_i(yumi),
    .heartbeat_o(hb)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  int idle [N];
  bit mto  [N];
  bit mpend[N];
  int cyc;

  typedef struct {
    logic       en;
    logic [3:0] act;
    logic [3:0] clr;
    logic       yumi;
    logic [3:0] to;
    logic       v;
    logic [1:0] id;
  } vec_t;

  vec_t tbl[14];

  task automatic chk(string nm, int got, int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d t=%0t", nm, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int c = 0; c < N; c++) begin
      idle[c] = 0;
      mto[c] = 0;
      mpend[c] = 0;
    end
    cyc = 0;
  endfunction

  function automatic void model_step();
    bit pre_v;
    int pre_id;
    pre_v = 0;
    pre_id = -1;
    for (int c = N - 1; c >= 0; c--) begin
      if (mpend[c]) begin
        pre_v = 1;
        pre_id = c;
      end
    end
    for (int c = 0; c < N; c++) begin
      if (clr[c]) begin
        idle[c] = 0;
        mto[c] = 0;
        mpend[c] = 0;
      end else if (mto[c]) begin
        if (yumi && pre_v && pre_id == c) mpend[c] = 0;
      end else if (act[c]) begin
        idle[c] = 0;
      end else if (en) begin
        idle[c]++;
        if (idle[c] == T) begin
          mto[c] = 1;
          mpend[c] = 1;
        end
      end
    end
    cyc++;
  endfunction

  function automatic int hb_exp();
`ifdef BSG_GATEWAY_WATCHDOG_HEARTBEAT_EN
    return (cyc > 0 && cyc % (1 << HB) == 0) ? 1 : 0;
`else
    return 0;
`endif
  endfunction

  task automatic compare_model();
    int eto;
    int ev;
    int eid;
    eto = 0;
    ev = 0;
    eid = 0;
    for (int c = N - 1; c >= 0; c--) begin
      if (mto[c]) eto = eto | (1 << c);
      if (mpend[c]) begin
        ev = 1;
        eid = c;
      end
    end
    chk("timeout_o", int'(timeout), eto);
    chk("any_timeout_o", int'(any_to), (eto != 0) ? 1 : 0);
    chk("event_v_o", int'(ev_v), ev);
    if (ev == 1) chk("event_id_o", int'(ev_id), eid);
    chk("heartbeat_o", int'(hb), hb_exp());
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    compare_model();
    @(negedge clk);
  endtask

  task automatic check_zero(string nm);
    chk({nm, "_to"}, int'(timeout), 0);
    chk({nm, "_any"}, int'(any_to), 0);
    chk({nm, "_v"}, int'(ev_v), 0);
    chk({nm, "_id"}, int'(ev_id), 0);
    chk({nm, "_hb"}, int'(hb), 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    en = 1'b0;
    act = '0;
    clr = '0;
    yumi = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    int first;
    bit seen;

    for (int i = 0; i < 7; i++) tbl[i] = '{1'b1, 4'b0101, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0};
    tbl[7]  = '{1'b1, 4'b0101, 4'b0000, 1'b0, 4'b1010, 1'b1, 2'd1};
    tbl[8]  = '{1'b1, 4'b0101, 4'b0000, 1'b1, 4'b1010, 1'b1, 2'd3};
    tbl[9]  = '{1'b1, 4'b0101, 4'b0000, 1'b1, 4'b1010, 1'b0, 2'd0};
    tbl[10] = '{1'b1, 4'b0101, 4'b0000, 1'b1, 4'b1010, 1'b0, 2'd0};
    tbl[11] = '{1'b1, 4'b0101, 4'b1000, 1'b0, 4'b0010, 1'b0, 2'd0};
    tbl[12] = '{1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0010, 1'b0, 2'd0};
    tbl[13] = '{1'b1, 4'b0101, 4'b0010, 1'b1, 4'b0000, 1'b0, 2'd0};

    model_reset();
    do_reset();

    // Table: channels 1 and 3 expire together, drained with yumi held.
    for (int i = 0; i < 14; i++) begin
      en = tbl[i].en;
      act = tbl[i].act;
      clr = tbl[i].clr;
      yumi = tbl[i].yumi;
      model_step();
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d_to", i), int'(timeout), int'(tbl[i].to));
      chk($sformatf("tbl%0d_v", i), int'(ev_v), int'(tbl[i].v));
      if (tbl[i].v) chk($sformatf("tbl%0d_id", i), int'(ev_id), int'(tbl[i].id));
      @(negedge clk);
    end

    // Plain expiry exactly T cycles after release.
    do_reset();
    en = 1'b1;
    for (int k = 1; k <= T; k++) begin
      step();
      chk($sformatf("A_to0_k%0d", k), int'(timeout[0]), (k == T) ? 1 : 0);
    end
    chk("A_v", int'(ev_v), 1);
    chk("A_id", int'(ev_id), 0);

    // Periodic activity keeps channel 0 alive.
    do_reset();
    en = 1'b1;
    seen = 0;
    for (int i = 0; i < 98; i++) begin
      act = (i % 7 == 0) ? 4'b0001 : 4'b0000;
      step();
      seen = seen | timeout[0];
    end
    act = 4'b0001;
    step();
    seen = seen | timeout[0];
    chk("B_alive", int'(seen), 0);
    act = '0;
    first = 0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (timeout[0] && first == 0) first = k;
    end
    chk("B_expire_after", first, T);

    // Clear in the expiry cycle wins; en low holds the counters.
    do_reset();
    en = 1'b1;
    for (int k = 0; k < T - 1; k++) step();
    clr = 4'hf;
    step();
    clr = '0;
    chk("C_to_clear", int'(timeout), 0);
    chk("C_v_clear", int'(ev_v), 0);
    en = 1'b0;
    for (int k = 0; k < 20; k++) step();
    chk("C_hold", int'(timeout), 0);
    en = 1'b1;
    for (int k = 0; k < T - 1; k++) step();
    chk("C_fresh_pre", int'(timeout), 0);
    step();
    chk("C_fresh", int'(timeout), 4'hf);

    // Async reset while an event is pending.
    do_reset();
    en = 1'b1;
    for (int k = 0; k < T; k++) step();
    chk("D_v_before", int'(ev_v), 1);
    #1 rst_n = 1'b0;
    #1 check_zero("D_async");
    do_reset();
    en = 1'b1;
    for (int k = 0; k < T - 1; k++) step();
    chk("D_fresh_pre", int'(timeout), 0);
    step();
    chk("D_fresh", int'(timeout), 4'hf);

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      en = ($urandom_range(0, 9) != 0);
      for (int c = 0; c < N; c++) begin
        act[c] = ($urandom_range(0, 11) == 0);
        clr[c] = ($urandom_range(0, 59) == 0);
      end
      yumi = $urandom_range(0, 1) == 1;
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
